// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared encodings for the unified memory port arbiter
//          (FSM states, owner identifiers, default timeout read data).
// Rev    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    // RV32I NOP (addi x0,x0,0): a harmless instruction handed back on timeout
    localparam logic [31:0] c_nop_insn = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Fetch, data and memory handshake bundle of the port arbiter.
//          slave  = arbiter side, master = CPU requesters plus memory.
// Rev    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // instruction fetch requester
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    // load/store requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    // unified memory port
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  m_req, m_we, m_addr, m_wdata,
        output m_rdata, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_timer
// Brief  : BUSY-cycle counter. Load sets it to 1 (first BUSY cycle), clear
//          zeroes it, enable advances it; o_term flags count == TIMEOUT.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_term
);
    localparam int c_cw = $clog2(TIMEOUT + 1);

    logic [c_cw-1:0] r_count;

    // Counter register: clear has priority, then load, then increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_cw'(1);
        end else if (i_en) begin
            r_count <= r_count + c_cw'(1);
        end
    end

    assign o_term = (r_count == c_cw'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one single-ported memory between instruction fetch and
//          load/store. IDLE -> BUSY -> RESP, one transaction at a time,
//          data priority bounded by MAX_DWIN, BUSY wait bounded by TIMEOUT.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            TIMEOUT  = 16,
    parameter int            MAX_DWIN = 4,
    parameter logic [DW-1:0] ERR_DATA = DW'(c_nop_insn)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  bus,
    output logic               busy,
    output logic               timeout_err
);
    localparam int c_dwin_w = $clog2(MAX_DWIN + 1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    arb_owner_t          r_owner;
    logic [AW-1:0]       r_addr;
    logic                r_we;
    logic [DW-1:0]       r_wdata;
    logic [c_dwin_w-1:0] r_dwin;
    logic [DW-1:0]       r_i_rdata;
    logic [DW-1:0]       r_d_rdata;
    logic                r_tout_err;

    logic          w_grant_data;
    logic          w_grant_fetch;
    logic          w_grant;
    logic          w_capture;
    logic          w_timeout;
    logic [DW-1:0] w_cap_data;
    logic          w_tmr_load;
    logic          w_tmr_clr;
    logic          w_tmr_en;
    logic          w_tmr_term;

    // Data wins unless fetch is waiting and data already had MAX_DWIN turns
    assign w_grant_data  = bus.d_req && (!bus.i_req || (r_dwin < c_dwin_w'(MAX_DWIN)));
    assign w_grant_fetch = !w_grant_data && bus.i_req;

    // Stores return 0; a timed-out access returns the NOP pattern
    assign w_cap_data = bus.m_ready ? (r_we ? '0 : bus.m_rdata) : ERR_DATA;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_clr  (w_tmr_clr),
        .i_en   (w_tmr_en),
        .o_term (w_tmr_term)
    );

    // State, request capture, fairness counter and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_FETCH;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_dwin     <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_tout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_owner <= w_grant_data ? OWN_DATA : OWN_FETCH;
                r_addr  <= w_grant_data ? bus.d_addr : bus.i_addr;
                r_we    <= w_grant_data && bus.d_we;
                r_wdata <= w_grant_data ? bus.d_wdata : '0;
                if (w_grant_data && bus.i_req) begin
                    if (r_dwin < c_dwin_w'(MAX_DWIN)) begin
                        r_dwin <= r_dwin + c_dwin_w'(1);
                    end
                end else begin
                    r_dwin <= '0;
                end
            end
            if (w_capture) begin
                if (r_owner == OWN_DATA) begin
                    r_d_rdata <= w_cap_data;
                end else begin
                    r_i_rdata <= w_cap_data;
                end
                if (w_timeout) begin
                    r_tout_err <= 1'b1;
                end
            end
        end
    end

    // Next state, memory request, acks and timer control
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_clr    = 1'b0;
        w_tmr_en     = 1'b0;
        bus.m_req    = 1'b0;
        bus.i_ack    = 1'b0;
        bus.d_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_data || w_grant_fetch) begin
                    w_grant      = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                bus.m_req = 1'b1;
                if (bus.m_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESP;
                end else if (w_tmr_term) begin
                    w_capture    = 1'b1;
                    w_timeout    = 1'b1;
                    w_next_state = ST_RESP;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_RESP: begin
                bus.i_ack    = (r_owner == OWN_FETCH);
                bus.d_ack    = (r_owner == OWN_DATA);
                w_tmr_clr    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign bus.m_we      = (r_state == ST_BUSY) && r_we;
    assign bus.m_addr    = r_addr;
    assign bus.m_wdata   = r_wdata;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign busy          = (r_state == ST_BUSY) || (r_state == ST_RESP);
    assign timeout_err   = r_tout_err;

endmodule
`default_nettype wire
